// File: rtl/cla_nibble_serial_adder.sv
// Wide adder sequencer around an external combinational 4-bit CLA stage.
// It feeds one nibble pair per cycle, LSB nibble first, and chains the CLA carry back in.
module cla_nibble_serial_adder #(
   parameter int NIBBLES = 4,
   localparam int W = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic [3:0]   cla_a,
   output logic [3:0]   cla_b,
   output logic         cla_cin,
   input  logic [4:0]   cla_s
);

   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                      state_q;
   logic [IDXW-1:0]             idx_q;
   logic                        carry_q;
   logic [NIBBLES-1:0][3:0]     a_q;
   logic [NIBBLES-1:0][3:0]     b_q;
   logic [NIBBLES-1:0][3:0]     sum_q;
   logic                        cout_q;
   logic                        in_ready_q;
   logic                        out_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  carry_q    <= cin;
                  idx_q      <= '0;
                  sum_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               // The CLA answers combinationally for the nibble selected by idx_q.
               sum_q[idx_q] <= cla_s[3:0];
               carry_q      <= cla_s[4];
               if (idx_q == LAST_IDX) begin
                  idx_q       <= '0;
                  cout_q      <= cla_s[4];
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  idx_q <= idx_q + IDXW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      cla_a   = 4'h0;
      cla_b   = 4'h0;
      cla_cin = 1'b0;
      if (state_q == S_RUN) begin
         cla_a   = a_q[idx_q];
         cla_b   = b_q[idx_q];
         cla_cin = carry_q;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Bench for cla_nibble_serial_adder: a 4-nibble and a 1-nibble instance, each wired to a behavioural CLA.
// Results are checked against a wide-arithmetic model queue plus literal expectations.
module tb_cla_nibble_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 4-nibble instance
   logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
   logic [15:0] a4 = '0, b4 = '0, sum4;
   logic        cin4 = 1'b0, cout4, cla_cin4;
   logic [3:0]  cla_a4, cla_b4;
   logic [4:0]  cla_s4;
   assign cla_s4 = {1'b0, cla_a4} + {1'b0, cla_b4} + {4'b0, cla_cin4};

   cla_nibble_serial_adder #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .cout(cout4), .cla_a(cla_a4), .cla_b(cla_b4), .cla_cin(cla_cin4),
      .cla_s(cla_s4)
   );

   // 1-nibble instance
   logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
   logic [3:0] a1 = '0, b1 = '0, sum1;
   logic       cin1 = 1'b0, cout1, cla_cin1;
   logic [3:0] cla_a1, cla_b1;
   logic [4:0] cla_s1;
   assign cla_s1 = {1'b0, cla_a1} + {1'b0, cla_b1} + {4'b0, cla_cin1};

   cla_nibble_serial_adder #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .cla_a(cla_a1), .cla_b(cla_b1), .cla_cin(cla_cin1),
      .cla_s(cla_s1)
   );

   // Expected {cout, sum} of every accepted add, oldest first
   logic [16:0] exp_q4[$];
   logic [4:0]  exp_q1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: any presented result must match the oldest model entry
   always @(negedge clk) begin
      if (!rst && out_valid4) begin
         if (exp_q4.size() == 0) chk("dut4_unexpected_result", 32'(out_valid4), 32'd0);
         else chk("dut4_model_result", {15'd0, cout4, sum4}, {15'd0, exp_q4[0]});
      end
      if (!rst && out_valid1) begin
         if (exp_q1.size() == 0) chk("dut1_unexpected_result", 32'(out_valid1), 32'd0);
         else chk("dut1_model_result", {27'd0, cout1, sum1}, {27'd0, exp_q1[0]});
      end
   end

   always @(posedge clk) begin
      if (!rst && out_valid4 && out_ready4 && exp_q4.size() != 0) void'(exp_q4.pop_front());
      if (!rst && out_valid1 && out_ready1 && exp_q1.size() != 0) void'(exp_q1.pop_front());
   end

   // Drives one add on the 4-nibble instance; called at #1 after an edge while the DUT is idle.
   task automatic add4(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       input int stall, input bit intrude,
                       input logic [15:0] sum_lit, input logic cout_lit);
      chk("in_ready_before_accept", 32'(in_ready4), 32'd1);
      a4 = av; b4 = bv; cin4 = ci; in_valid4 = 1'b1;
      out_ready4 = (stall == 0);
      @(posedge clk); #1;
      exp_q4.push_back({1'b0, av} + {1'b0, bv} + {16'd0, ci});
      in_valid4 = 1'b0;
      a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
         chk("cla_a_nibble", 32'(cla_a4), 32'(av[4*i +: 4]));
         chk("cla_b_nibble", 32'(cla_b4), 32'(bv[4*i +: 4]));
         if (i == 0) chk("cla_cin_first", 32'(cla_cin4), 32'(ci));
         chk("in_ready_run", 32'(in_ready4), 32'd0);
         chk("out_valid_run", 32'(out_valid4), 32'd0);
         if (intrude && i == 1) begin
            in_valid4 = 1'b1; a4 = 16'hAAAA;
         end
         @(posedge clk); #1;
         in_valid4 = 1'b0;
      end
      chk("out_valid_latency", 32'(out_valid4), 32'd1);
      chk("sum_literal", 32'(sum4), 32'(sum_lit));
      chk("cout_literal", 32'(cout4), 32'(cout_lit));
      chk("cla_a_zero_done", 32'({cla_a4, cla_b4, cla_cin4}), 32'd0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         chk("out_valid_stall", 32'(out_valid4), 32'd1);
         chk("in_ready_stall", 32'(in_ready4), 32'd0);
         chk("sum_stall", {15'd0, cout4, sum4}, {15'd0, cout_lit, sum_lit});
      end
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      chk("out_valid_drop", 32'(out_valid4), 32'd0);
      chk("in_ready_back", 32'(in_ready4), 32'd1);
      out_ready4 = 1'b0;
   endtask

   initial begin
      logic [3:0] va[3];
      logic [3:0] vb[3];
      logic       vc[3];
      va = '{4'hF, 4'h7, 4'h9};
      vb = '{4'h1, 4'h8, 4'h9};
      vc = '{1'b1, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset_in_ready", 32'(in_ready4), 32'd1);
      chk("reset_out_valid", 32'(out_valid4), 32'd0);
      chk("reset_sum_cout", {15'd0, cout4, sum4}, 32'd0);
      chk("reset_cla", 32'({cla_a4, cla_b4, cla_cin4}), 32'd0);

      add4(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 16'h0000, 1'b1);
      add4(16'h1234, 16'h4321, 1'b1, 0, 1'b0, 16'h5556, 1'b0);
      add4(16'h8000, 16'h8000, 1'b0, 3, 1'b0, 16'h0000, 1'b1);
      add4(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b1, 16'h1000, 1'b0);

      // Reset during the second RUN cycle discards the add
      a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q4.delete();
      chk("midrst_in_ready", 32'(in_ready4), 32'd1);
      chk("midrst_out_valid", 32'(out_valid4), 32'd0);
      chk("midrst_sum_cout", {15'd0, cout4, sum4}, 32'd0);
      chk("midrst_cla", 32'({cla_a4, cla_b4, cla_cin4}), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("midrst_no_valid", 32'(out_valid4), 32'd0);
      end
      out_ready4 = 1'b0;
      add4(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 16'h0002, 1'b0);

      // 1-nibble instance: back-to-back requests with in_valid held high
      out_ready1 = 1'b1;
      in_valid1  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a1 = va[k]; b1 = vb[k]; cin1 = vc[k];
         chk("n1_in_ready_idle", 32'(in_ready1), 32'd1);
         @(posedge clk); #1;
         exp_q1.push_back({1'b0, va[k]} + {1'b0, vb[k]} + {4'd0, vc[k]});
         a1 = 4'($urandom);
         chk("n1_in_ready_run", 32'(in_ready1), 32'd0);
         chk("n1_out_valid_run", 32'(out_valid1), 32'd0);
         @(posedge clk); #1;
         chk("n1_out_valid_done", 32'(out_valid1), 32'd1);
         chk("n1_in_ready_done", 32'(in_ready1), 32'd0);
         if (k == 0) chk("n1_literal", {27'd0, cout1, sum1}, 32'h11);
         @(posedge clk); #1;
      end
      in_valid1 = 1'b0;
      chk("n1_idle_after", 32'(out_valid1), 32'd0);
      chk("model_queues_drained", 32'(exp_q4.size() + exp_q1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
